// File: rtl/isp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : isp_pkg
// Brief    : Shared ISP line-buffer constants (pixel width, line RAM geometry).
// Revision : 1.0 - initial release
// ============================================================================
package isp_pkg;

    localparam int ISP_DATA_W      = 8;
    localparam int ISP_LINE_ADDR_W = 12;
    localparam int ISP_MAX_WIDTH   = 4096;

endpackage
`default_nettype wire

// File: rtl/isp_line_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : isp_line_delay_ctrl
// Brief    : Line RAM write/read controller; pairs each pixel with the one above.
// Revision : 1.0 - initial release
// ============================================================================
module isp_line_delay_ctrl
    import isp_pkg::*;
#(
    parameter int DATA_W    = ISP_DATA_W,
    parameter int ADDR_W    = ISP_LINE_ADDR_W,
    parameter int MAX_WIDTH = ISP_MAX_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_eol,
    input  logic              in_eof,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_oce,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_cur,
    output logic [DATA_W-1:0] out_prev,
    output logic              out_prev_ok,
    output logic              out_eol,
    output logic              out_eof,
    output logic [ADDR_W:0]   line_width,
    output logic              err_ovf
);

    localparam logic [ADDR_W-1:0] c_col_last = ADDR_W'(MAX_WIDTH - 1);
    localparam logic [ADDR_W-1:0] c_col_one  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_lw_one   = (ADDR_W + 1)'(1);

    logic [ADDR_W-1:0] r_col;
    logic              r_first_line;
    logic [ADDR_W:0]   r_line_width;
    logic              r_err_ovf;

    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic [ADDR_W-1:0] r_s1_col;
    logic              r_s1_eol;
    logic              r_s1_eof;
    logic              r_s1_first;
    logic              r_s1_byp;
    logic [DATA_W-1:0] r_s1_byp_data;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_cur;
    logic [DATA_W-1:0] r_out_prev;
    logic              r_out_prev_ok;
    logic              r_out_eol;
    logic              r_out_eof;

    logic              w_byp;
    logic              w_col_wrap;

    // A read colliding with the write in flight only happens on 1-pixel lines;
    // the RAM would return the old word, so the in-flight pixel is forwarded.
    assign w_byp      = in_valid & r_s1_valid & (r_s1_col == r_col);
    assign w_col_wrap = ~in_eol & (r_col == c_col_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col        <= '0;
            r_first_line <= 1'b1;
            r_line_width <= '0;
            r_err_ovf    <= 1'b0;
        end else if (in_valid) begin
            if (in_eol) begin
                r_col        <= '0;
                r_line_width <= {1'b0, r_col} + c_lw_one;
                r_first_line <= in_eof;
            end else if (w_col_wrap) begin
                r_col <= '0;
            end else begin
                r_col <= r_col + c_col_one;
            end

            if (w_col_wrap) begin
                r_err_ovf <= 1'b1;
            end else if (in_eol & in_eof) begin
                r_err_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid    <= 1'b0;
            r_s1_data     <= '0;
            r_s1_col      <= '0;
            r_s1_eol      <= 1'b0;
            r_s1_eof      <= 1'b0;
            r_s1_first    <= 1'b0;
            r_s1_byp      <= 1'b0;
            r_s1_byp_data <= '0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data     <= in_data;
                r_s1_col      <= r_col;
                r_s1_eol      <= in_eol;
                r_s1_eof      <= in_eol & in_eof;
                r_s1_first    <= r_first_line;
                r_s1_byp      <= w_byp;
                r_s1_byp_data <= r_s1_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid   <= 1'b0;
            r_out_cur     <= '0;
            r_out_prev    <= '0;
            r_out_prev_ok <= 1'b0;
            r_out_eol     <= 1'b0;
            r_out_eof     <= 1'b0;
        end else begin
            r_out_valid <= r_s1_valid;
            r_out_eol   <= r_s1_valid & r_s1_eol;
            r_out_eof   <= r_s1_valid & r_s1_eof;
            if (r_s1_valid) begin
                r_out_cur     <= r_s1_data;
                r_out_prev    <= r_s1_byp ? r_s1_byp_data : mem_rd_data;
                r_out_prev_ok <= ~r_s1_first;
            end
        end
    end

    // Write lags read by one cycle so the previous line's word is fetched first.
    assign mem_wr_en   = r_s1_valid;
    assign mem_wr_addr = r_s1_col;
    assign mem_wr_data = r_s1_data;
    assign mem_rd_en   = in_valid;
    assign mem_rd_addr = r_col;
    assign mem_oce     = 1'b1;

    assign out_valid   = r_out_valid;
    assign out_cur     = r_out_cur;
    assign out_prev    = r_out_prev;
    assign out_prev_ok = r_out_prev_ok;
    assign out_eol     = r_out_eol;
    assign out_eof     = r_out_eof;
    assign line_width  = r_line_width;
    assign err_ovf     = r_err_ovf;

endmodule
`default_nettype wire

// File: tb/tb_isp_line_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_isp_line_delay_ctrl
// Brief    : Directed/random bench for isp_line_delay_ctrl with a line model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_isp_line_delay_ctrl;

    localparam int DW = 8;
    localparam int AW = 12;
    localparam int MW = 4096;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_eol = 1'b0;
    logic          in_eof = 1'b0;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic          mem_oce;
    logic [DW-1:0] mem_rd_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_cur;
    logic [DW-1:0] out_prev;
    logic          out_prev_ok;
    logic          out_eol;
    logic          out_eof;
    logic [AW:0]   line_width;
    logic          err_ovf;

    int tests_run    = 0;
    int tests_failed = 0;
    int wr_count     = 0;

    always #5 clk = ~clk;

    isp_line_delay_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_eol      (in_eol),
        .in_eof      (in_eof),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .mem_wr_data (mem_wr_data),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_oce     (mem_oce),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_cur     (out_cur),
        .out_prev    (out_prev),
        .out_prev_ok (out_prev_ok),
        .out_eol     (out_eol),
        .out_eof     (out_eof),
        .line_width  (line_width),
        .err_ovf     (err_ovf)
    );

    // Line RAM: registered read (old data on collision), one cycle latency.
    logic [DW-1:0] ram [0:MW-1];
    always @(posedge clk) begin
        if (mem_rd_en && mem_oce) mem_rd_data <= ram[mem_rd_addr];
        if (mem_wr_en) begin
            ram[mem_wr_addr] <= mem_wr_data;
            wr_count         <= wr_count + 1;
        end
    end

    // Reference: the line as a picture. m_mem[c] is the last pixel seen in column c.
    typedef struct {
        bit            v;
        logic [DW-1:0] cur;
        logic [DW-1:0] prev;
        bit            ok;
        bit            eol;
        bit            eof;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] m_mem [0:MW-1];
    int            m_col   = 0;
    bit            m_first = 1'b1;
    int            m_lw    = 0;
    bit            m_err   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input bit eol, input bit eof);
        exp_t e;
        exp_t o;
        in_valid = v;
        in_data  = d;
        in_eol   = eol;
        in_eof   = eof;
        e.v    = v;
        e.cur  = d;
        e.prev = m_mem[m_col];
        e.ok   = !m_first;
        e.eol  = eol;
        e.eof  = eol && eof;
        if (v) begin
            m_mem[m_col] = d;
            if (eol) begin
                m_lw    = m_col + 1;
                m_col   = 0;
                m_first = eof;
                if (eof) m_err = 1'b0;
            end else if (m_col == MW - 1) begin
                m_col = 0;
                m_err = 1'b1;
            end else begin
                m_col++;
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        chk("line_width", 32'(line_width), m_lw);
        chk("err_ovf", 32'(err_ovf), 32'(m_err));
        if (exp_q.size() > 1) begin
            o = exp_q.pop_front();
            chk("out_valid", 32'(out_valid), 32'(o.v));
            if (o.v) begin
                chk("out_cur", 32'(out_cur), 32'(o.cur));
                chk("out_prev_ok", 32'(out_prev_ok), 32'(o.ok));
                chk("out_eol", 32'(out_eol), 32'(o.eol));
                chk("out_eof", 32'(out_eof), 32'(o.eof));
                if (o.ok) chk("out_prev", 32'(out_prev), 32'(o.prev));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    // gap: 0 none, 1 idle after every pixel, 2 random idles
    task automatic send_line(input int n, input int base, input bit rnd, input int gap, input bit eof);
        logic [DW-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? DW'($urandom) : DW'(base + i);
            step(1'b1, d, i == n - 1, eof && (i == n - 1));
            if (gap == 1) idle(1);
            if (gap == 2 && $urandom_range(0, 3) == 0) idle(1);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_eol   = 1'b0;
        in_eof   = 1'b0;
        in_data  = '0;
        reset    = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_cur", 32'(out_cur), 0);
        chk("rst_out_prev", 32'(out_prev), 0);
        chk("rst_out_prev_ok", 32'(out_prev_ok), 0);
        chk("rst_out_eol", 32'(out_eol), 0);
        chk("rst_out_eof", 32'(out_eof), 0);
        chk("rst_line_width", 32'(line_width), 0);
        chk("rst_err_ovf", 32'(err_ovf), 0);
        chk("rst_mem_wr_en", 32'(mem_wr_en), 0);
        chk("rst_mem_rd_addr", 32'(mem_rd_addr), 0);
        chk("rst_mem_oce", 32'(mem_oce), 1);
        exp_q.delete();
        m_col   = 0;
        m_first = 1'b1;
        m_err   = 1'b0;
        m_lw    = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int w0;
        logic [DW-1:0] d;

        do_reset();

        // two 8-px lines, data = col + 16*line
        send_line(8, 0, 1'b0, 0, 1'b0);
        send_line(8, 16, 1'b0, 0, 1'b1);
        idle(3);

        // same lines with in_valid toggling; writes must match pixels
        w0 = wr_count;
        send_line(8, 0, 1'b0, 1, 1'b0);
        send_line(8, 16, 1'b0, 1, 1'b1);
        idle(3);
        chk("t2_write_count", 32'(wr_count - w0), 16);
        chk("t2_line_width", 32'(line_width), 8);

        // 1-px lines back to back exercise the bypass
        for (int k = 0; k < 4; k++) send_line(1, 8'hA1 + k, 1'b0, 0, k == 3);
        idle(3);

        // overlong line, then an eol+eof pixel clears the error
        send_line(MW + 1, 0, 1'b1, 0, 1'b0);
        chk("t4_err_set", 32'(err_ovf), 1);
        chk("t4_lw_after_wrap", 32'(line_width), 1);
        step(1'b1, DW'($urandom), 1'b1, 1'b1);
        chk("t4_err_clr", 32'(err_ovf), 0);
        send_line(2, 0, 1'b1, 0, 1'b1);
        idle(3);

        // reset in the middle of a line
        send_line(8, 0, 1'b1, 0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, DW'($urandom), 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            d = DW'($urandom);
            step(1'b1, d, i == 7, 1'b0);
            if (i == 0) begin
                chk("t5_wr_en", 32'(mem_wr_en), 1);
                chk("t5_wr_addr", 32'(mem_wr_addr), 0);
                chk("t5_wr_data", 32'(mem_wr_data), 32'(d));
            end
        end
        send_line(8, 0, 1'b1, 2, 1'b1);
        idle(3);

        // full-width lines
        send_line(MW, 0, 1'b1, 0, 1'b0);
        send_line(MW, 0, 1'b1, 0, 1'b0);
        send_line(MW, 0, 1'b1, 0, 1'b1);
        idle(3);
        chk("t6_line_width", 32'(line_width), MW);
        chk("t6_err_ovf", 32'(err_ovf), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
